// File: rtl/cpu_pkg.sv
// Shared pipeline types for the forwarding / hazard controller:
// operand-mux select encodings, the stage record, and the forward-select helper.
package cpu_pkg;

    localparam logic [1:0] FWD_IDEX  = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       regWrite;
        logic       memRead;
    } stage_rec_t;

    // A producer can forward only if it really writes a
    // non-zero register that the consumer reads.
    function automatic logic wr_hit(
        input stage_rec_t r,
        input logic [4:0] src
    );
        return r.valid && r.regWrite
            && (r.rd != 5'd0) && (r.rd == src);
    endfunction

    // EX/MEM is younger than MEM/WB, so it wins a double hit.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input stage_rec_t ex,
        input stage_rec_t mem,
        input stage_rec_t wb
    );
        logic [1:0] sel;
        sel = FWD_IDEX;
        if (ex.valid) begin
            if (wr_hit(mem, src))
                sel = FWD_EXMEM;
            else if (wr_hit(wb, src))
                sel = FWD_MEMWB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/stage_record_reg.sv
// One pipeline stage record register with hold and bubble controls.
// Ports: clk_i, rst_i, hold_i (keep), bubble_i (load empty), d_i, q_o.
import cpu_pkg::*;

module stage_record_reg (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       hold_i,
    input  logic       bubble_i,
    input  stage_rec_t d_i,
    output stage_rec_t q_o
);

    stage_rec_t rec_q;
    stage_rec_t rec_d;

    // Hold dominates bubble so a frozen pipe never loses a record.
    always_comb begin
        rec_d = rec_q;
        if (!hold_i)
            rec_d = bubble_i ? '0 : d_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            rec_q <= '0;
        else
            rec_q <= rec_d;
    end

    assign q_o = rec_q;

endmodule

// File: rtl/forward_hazard_ctrl.sv
// Operand forwarding, load-use stall and memory-wait freeze control.
// Ports: ID regs/flags in, memReady_i, forward selects, stall/freeze, stallCount_o.
import cpu_pkg::*;

module forward_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       rs1_i,
    input  logic [4:0]       rs2_i,
    input  logic [4:0]       rd_i,
    input  logic             valid_i,
    input  logic             regWrite_i,
    input  logic             memRead_i,
    input  logic             flush_i,
    input  logic             memReady_i,
    output logic [1:0]       forwardA_o,
    output logic [1:0]       forwardB_o,
    output logic             stall_o,
    output logic             freeze_o,
    output logic [CNT_W-1:0] stallCount_o
);

    stage_rec_t id_rec;
    stage_rec_t ex_q;
    stage_rec_t mem_q;
    stage_rec_t wb_q;

    logic freeze;
    logic ld_hit;
    logic load_use;
    logic ex_bubble;
    logic stall;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign id_rec = '{
        valid:    valid_i,
        rs1:      rs1_i,
        rs2:      rs2_i,
        rd:       rd_i,
        regWrite: regWrite_i,
        memRead:  memRead_i
    };

    assign freeze = mem_q.valid && mem_q.memRead
                 && !memReady_i;

    assign ld_hit = (ex_q.rd != 5'd0)
                 && ((ex_q.rd == rs1_i)
                  || (ex_q.rd == rs2_i));

    assign load_use = !freeze && valid_i
                   && ex_q.valid && ex_q.memRead
                   && ld_hit;

    // A taken branch kills the dependent, so no stall is needed.
    assign stall = freeze || (load_use && !flush_i);

    assign ex_bubble = load_use || flush_i;

    stage_record_reg u_ex (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .hold_i   (freeze),
        .bubble_i (ex_bubble),
        .d_i      (id_rec),
        .q_o      (ex_q)
    );

    stage_record_reg u_mem (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .hold_i   (freeze),
        .bubble_i (1'b0),
        .d_i      (ex_q),
        .q_o      (mem_q)
    );

    stage_record_reg u_wb (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .hold_i   (freeze),
        .bubble_i (1'b0),
        .d_i      (mem_q),
        .q_o      (wb_q)
    );

    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != '1))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign forwardA_o   = fwd_sel(ex_q.rs1, ex_q, mem_q, wb_q);
    assign forwardB_o   = fwd_sel(ex_q.rs2, ex_q, mem_q, wb_q);
    assign stall_o      = stall;
    assign freeze_o     = freeze;
    assign stallCount_o = cnt_q;

endmodule

// File: tb/tb_forward_hazard_ctrl.sv
// Self-checking bench for forward_hazard_ctrl: pipeline model plus
// directed scenarios with literal expectations.
module tb_forward_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       rs1, rs2, rd;
    logic             valid, rw, mr, flush, mrdy;
    logic [1:0]       fa, fb;
    logic             stall, freeze;
    logic [CNT_W-1:0] cnt;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    forward_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .rs1_i        (rs1),
        .rs2_i        (rs2),
        .rd_i         (rd),
        .valid_i      (valid),
        .regWrite_i   (rw),
        .memRead_i    (mr),
        .flush_i      (flush),
        .memReady_i   (mrdy),
        .forwardA_o   (fa),
        .forwardB_o   (fb),
        .stall_o      (stall),
        .freeze_o     (freeze),
        .stallCount_o (cnt)
    );

    // Model: index 0 = EX, 1 = MEM, 2 = WB.
    logic       m_v  [3];
    logic [4:0] m_rs1[3];
    logic [4:0] m_rs2[3];
    logic [4:0] m_rd [3];
    logic       m_rw [3];
    logic       m_mr [3];
    int         m_cnt;

    function automatic logic [1:0] e_fwd(input logic [4:0] src);
        logic [1:0] r;
        r = 2'b00;
        if (m_v[0])
            for (int s = 2; s >= 1; s--)
                if (m_v[s] && m_rw[s] && m_rd[s] != 0 && m_rd[s] == src)
                    r = (s == 1) ? 2'b10 : 2'b01;
        return r;
    endfunction

    function automatic logic e_frz();
        return m_v[1] && m_mr[1] && !mrdy;
    endfunction

    function automatic logic e_lu();
        return !e_frz() && valid && m_v[0] && m_mr[0]
            && m_rd[0] != 0
            && (m_rd[0] == rs1 || m_rd[0] == rs2);
    endfunction

    function automatic logic e_stall();
        return e_frz() || (e_lu() && !flush);
    endfunction

    function automatic int e_cnt();
        return (m_cnt > CMAX) ? CMAX : m_cnt;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < 3; s++) begin
                m_v[s] <= 1'b0; m_rs1[s] <= '0; m_rs2[s] <= '0;
                m_rd[s] <= '0; m_rw[s] <= 1'b0; m_mr[s] <= 1'b0;
            end
            m_cnt <= 0;
        end else begin
            if (e_stall())
                m_cnt <= m_cnt + 1;
            if (!e_frz()) begin
                for (int s = 2; s >= 1; s--) begin
                    m_v[s] <= m_v[s-1]; m_rs1[s] <= m_rs1[s-1];
                    m_rs2[s] <= m_rs2[s-1]; m_rd[s] <= m_rd[s-1];
                    m_rw[s] <= m_rw[s-1]; m_mr[s] <= m_mr[s-1];
                end
                if (e_lu() || flush) begin
                    m_v[0] <= 1'b0;
                end else begin
                    m_v[0] <= valid; m_rs1[0] <= rs1; m_rs2[0] <= rs2;
                    m_rd[0] <= rd; m_rw[0] <= rw; m_mr[0] <= mr;
                end
            end
        end
    end

    task automatic chk(input string nm,
                       input logic [15:0] act,
                       input logic [15:0] exp);
        n_tot++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        chk("mdl.fwdA", 16'(fa), 16'(e_fwd(m_rs1[0])));
        chk("mdl.fwdB", 16'(fb), 16'(e_fwd(m_rs2[0])));
        chk("mdl.stall", 16'(stall), 16'(e_stall()));
        chk("mdl.freeze", 16'(freeze), 16'(e_frz()));
        chk("mdl.cnt", 16'(cnt), 16'(e_cnt()));
    end

    task automatic lit(input string tag, input logic [1:0] efa,
                       input logic [1:0] efb, input logic est,
                       input logic efz, input int ecnt);
        chk({tag, ".fwdA"}, 16'(fa), 16'(efa));
        chk({tag, ".fwdB"}, 16'(fb), 16'(efb));
        chk({tag, ".stall"}, 16'(stall), 16'(est));
        chk({tag, ".freeze"}, 16'(freeze), 16'(efz));
        chk({tag, ".cnt"}, 16'(cnt), 16'(ecnt));
    endtask

    task automatic ins(input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d, input logic w,
                       input logic m);
        rs1 = a; rs2 = b; rd = d;
        valid = 1'b1; rw = w; mr = m;
    endtask

    task automatic nop();
        rs1 = '0; rs2 = '0; rd = '0;
        valid = 1'b0; rw = 1'b0; mr = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drain();
        nop();
        repeat (3) step();
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; mrdy = 1'b1;
        nop();
        #1 rst = 1'b1;
        settle();
        lit("reset", 2'b00, 2'b00, 1'b0, 1'b0, 0);
        step();
        rst = 1'b0;

        // ALU chain, back-to-back then one apart
        ins(1, 2, 5, 1, 0); step();
        ins(5, 6, 8, 1, 0); step();
        nop(); settle();
        lit("alu_adj", 2'b10, 2'b00, 1'b0, 1'b0, 0);
        drain();
        ins(1, 2, 5, 1, 0); step();
        ins(1, 2, 9, 1, 0); step();
        ins(5, 6, 8, 1, 0); step();
        nop(); settle();
        lit("alu_gap", 2'b01, 2'b00, 1'b0, 1'b0, 0);
        drain();

        // double hit on x7
        ins(1, 2, 7, 1, 0); step();
        ins(1, 2, 7, 1, 0); step();
        ins(0, 7, 10, 1, 0); step();
        nop(); settle();
        lit("dbl_hit", 2'b00, 2'b10, 1'b0, 1'b0, 0);
        drain();

        // load-use on x3
        ins(1, 0, 3, 1, 1); step();
        ins(3, 4, 11, 1, 0); settle();
        lit("lu_stall", 2'b00, 2'b00, 1'b1, 1'b0, 0);
        step(); settle();
        lit("lu_bubble", 2'b00, 2'b00, 1'b0, 1'b0, 1);
        step();
        nop(); settle();
        lit("lu_fwd", 2'b01, 2'b00, 1'b0, 1'b0, 1);
        drain();

        // freeze for 3 cycles with a flush pulse inside
        ins(1, 2, 9, 1, 0); step();
        ins(1, 0, 4, 1, 1); step();
        ins(9, 2, 12, 1, 0); step();
        ins(13, 13, 14, 1, 0);
        mrdy = 1'b0; settle();
        lit("frz1", 2'b01, 2'b00, 1'b1, 1'b1, 1);
        step();
        flush = 1'b1; settle();
        lit("frz2", 2'b01, 2'b00, 1'b1, 1'b1, 2);
        step();
        flush = 1'b0; settle();
        lit("frz3", 2'b01, 2'b00, 1'b1, 1'b1, 3);
        step();
        mrdy = 1'b1; settle();
        lit("frz_end", 2'b01, 2'b00, 1'b0, 1'b0, 4);
        step();
        drain();

        // x0 never forwards
        ins(1, 2, 0, 1, 0); step();
        ins(0, 0, 15, 1, 0); step();
        nop(); settle();
        lit("x0", 2'b00, 2'b00, 1'b0, 1'b0, 4);
        drain();

        // flush coincident with load-use
        ins(1, 0, 3, 1, 1); step();
        ins(3, 0, 17, 1, 0);
        flush = 1'b1; settle();
        lit("fl_lu", 2'b00, 2'b00, 1'b0, 1'b0, 4);
        step();
        flush = 1'b0;
        nop(); settle();
        lit("fl_bubble", 2'b00, 2'b00, 1'b0, 1'b0, 4);
        drain();

        // saturation then async reset mid-freeze
        ins(1, 0, 6, 1, 1); step();
        nop(); step();
        mrdy = 1'b0; settle();
        lit("sat_start", 2'b00, 2'b00, 1'b1, 1'b1, 4);
        repeat (20) step();
        settle();
        lit("sat", 2'b00, 2'b00, 1'b1, 1'b1, CMAX);
        rst = 1'b1;
        #1;
        lit("rst_async", 2'b00, 2'b00, 1'b0, 1'b0, 0);
        step();
        rst = 1'b0;
        mrdy = 1'b1;
        ins(1, 2, 5, 1, 0); step();
        ins(5, 0, 8, 1, 0); step();
        nop(); settle();
        lit("post_rst", 2'b10, 2'b00, 1'b0, 1'b0, 0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
